// File: rtl/gpio_bus_arbiter.sv
// Two-master arbiter for a single register-mapped GPIO slave.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed m0 priority.
module gpio_bus_arbiter #(
   parameter int DW = 32,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_a,
   input  logic [DW-1:0] m0_wd,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_a,
   input  logic [DW-1:0] m1_wd,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_ack,
   output logic          m1_ack,
   output logic [DW-1:0] rd,
   output logic [AW-1:0] s_a,
   output logic          s_we,
   output logic [DW-1:0] s_wd,
   input  logic [DW-1:0] s_rd
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic          r_win;
   logic          w_win;
   logic          w_any_req;
   logic [DW-1:0] r_rd;
   logic [AW-1:0] r_s_a;
   logic          r_s_we;
   logic [DW-1:0] r_s_wd;

`ifdef ARB_ROUND_ROBIN_EN
   logic          r_last_win;

   // On a tie the master that did not win last time goes first
   always_comb begin
      w_any_req = m0_req | m1_req;
      if (m0_req && m1_req) begin
         w_win = ~r_last_win;
      end else begin
         w_win = m1_req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_win <= 1'b1;
      end else if (r_state == IDLE && w_any_req) begin
         r_last_win <= w_win;
      end
   end
`else
   always_comb begin
      w_any_req = m0_req | m1_req;
      w_win     = m1_req & ~m0_req;
   end
`endif

   always_comb begin
      w_state_nx = r_state;
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      m0_ack     = 1'b0;
      m1_ack     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_nx = ACCESS;
            end
         end
         ACCESS: begin
            w_state_nx = ACK;
            m0_gnt     = ~r_win;
            m1_gnt     = r_win;
         end
         ACK: begin
            w_state_nx = IDLE;
            m0_gnt     = ~r_win;
            m1_gnt     = r_win;
            m0_ack     = ~r_win;
            m1_ack     = r_win;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Request fields are latched once so later input changes cannot leak in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win  <= 1'b0;
         r_s_a  <= '0;
         r_s_we <= 1'b0;
         r_s_wd <= '0;
         r_rd   <= '0;
      end else begin
         if (r_state == IDLE && w_any_req) begin
            r_win  <= w_win;
            r_s_we <= w_win ? m1_we : m0_we;
            r_s_a  <= w_win ? m1_a  : m0_a;
            r_s_wd <= w_win ? m1_wd : m0_wd;
         end else if (r_state == ACCESS) begin
            r_s_we <= 1'b0;
            r_rd   <= r_s_we ? '0 : s_rd;
         end
      end
   end

   assign rd   = r_rd;
   assign s_a  = r_s_a;
   assign s_we = r_s_we;
   assign s_wd = r_s_wd;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Random and directed bench for gpio_bus_arbiter against a transaction model.
// Tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_gpio_bus_arbiter;

   localparam int DW = 32;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m1_req, m0_we, m1_we;
   logic [AW-1:0] m0_a, m1_a;
   logic [DW-1:0] m0_wd, m1_wd;
   logic          m0_gnt, m1_gnt, m0_ack, m1_ack;
   logic [DW-1:0] rd;
   logic [AW-1:0] s_a;
   logic          s_we;
   logic [DW-1:0] s_wd;
   logic [DW-1:0] s_rd;

   int n_chk = 0;
   int n_err = 0;

   logic [DW-1:0] slv_mem [4] = '{default: '0};

   gpio_bus_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_wd(m0_wd),
      .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_wd(m1_wd),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_ack(m0_ack), .m1_ack(m1_ack),
      .rd(rd), .s_a(s_a), .s_we(s_we), .s_wd(s_wd), .s_rd(s_rd)
   );

   always #5 clk = ~clk;

   // Slave register file: combinational read, write on rising edge
   assign s_rd = slv_mem[s_a];
   always @(posedge clk) begin
      if (s_we) slv_mem[s_a] <= s_wd;
   end

   // Transaction-level reference model
   logic [DW-1:0] mdl_mem [4] = '{default: '0};
   bit            busy;
   int            phase;
   bit            cur_win;
   bit            cur_we;
   logic [AW-1:0] cur_a;
   logic [DW-1:0] cur_wd;
   logic [DW-1:0] exp_rd;
   bit            last_win;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      busy     = 0;
      phase    = 0;
      cur_win  = 0;
      cur_we   = 0;
      cur_a    = '0;
      cur_wd   = '0;
      exp_rd   = '0;
      last_win = 1;
   endtask

   function automatic bit pick_winner();
      if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         return !last_win;
`else
         return 0;
`endif
      end
      return m1_req;
   endfunction

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (!busy) begin
         if (m0_req || m1_req) begin
            cur_win  = pick_winner();
            cur_we   = cur_win ? m1_we : m0_we;
            cur_a    = cur_win ? m1_a  : m0_a;
            cur_wd   = cur_win ? m1_wd : m0_wd;
            last_win = cur_win;
            busy     = 1;
            phase    = 1;
         end
      end else if (phase == 1) begin
         if (cur_we) begin
            mdl_mem[cur_a] = cur_wd;
            exp_rd = '0;
         end else begin
            exp_rd = mdl_mem[cur_a];
         end
         phase = 2;
      end else begin
         busy  = 0;
         phase = 0;
      end
   endtask

   task automatic check_outputs();
      chk("gnt0", m0_gnt, busy && !cur_win);
      chk("gnt1", m1_gnt, busy && cur_win);
      chk("ack0", m0_ack, busy && phase == 2 && !cur_win);
      chk("ack1", m1_ack, busy && phase == 2 && cur_win);
      chk("s_we", s_we, busy && phase == 1 && cur_we);
      chk("s_a", s_a, cur_a);
      chk("s_wd", s_wd, cur_wd);
      chk("rd", rd, exp_rd);
      chk("gnt_excl", m0_gnt & m1_gnt, 0);
      chk("ack_excl", m0_ack & m1_ack, 0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic clear_reqs();
      m0_req = 0;
      m1_req = 0;
   endtask

   task automatic txn(input bit m, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
      if (m) begin
         m1_req = 1; m1_we = we; m1_a = a; m1_wd = wd;
      end else begin
         m0_req = 1; m0_we = we; m0_a = a; m0_wd = wd;
      end
      step();
      clear_reqs();
      step();
      step();
   endtask

   int g1_cycles;

   initial begin
      rst = 1;
      m0_req = 0; m0_we = 0; m0_a = '0; m0_wd = '0;
      m1_req = 0; m1_we = 0; m1_a = '0; m1_wd = '0;
      model_reset();
      step();
      step();
      chk("rst_rd", rd, 0);
      rst = 0;
      step();

      // Single write by m0, request dropped during ACCESS
      m0_req = 1; m0_we = 1; m0_a = 0; m0_wd = 32'h0000_00A5;
      step();
      chk("wr_gnt", m0_gnt, 1);
      chk("wr_swe", s_we, 1);
      chk("wr_swd", s_wd, 32'hA5);
      clear_reqs();
      step();
      chk("wr_ack", m0_ack, 1);
      chk("wr_swe_off", s_we, 0);
      chk("wr_rd", rd, 0);
      step();
      chk("wr_mem", slv_mem[0], 32'hA5);

      // Single read by m1
      txn(0, 1, 2, 32'h1234_5678);
      m1_req = 1; m1_we = 0; m1_a = 2;
      step();
      chk("rd_gnt", m1_gnt, 1);
      clear_reqs();
      step();
      chk("rd_ack", m1_ack, 1);
      chk("rd_val", rd, 32'h1234_5678);
      step();
      chk("rd_hold", rd, 32'h1234_5678);

      // Write data changed while in flight
      m0_req = 1; m0_we = 1; m0_a = 1; m0_wd = 32'h11;
      step();
      m0_wd = 32'h22;
      #1 chk("chg_swd", s_wd, 32'h11);
      step();
      clear_reqs();
      step();
      chk("chg_mem", slv_mem[1], 32'h11);
      txn(0, 0, 1, 0);
      chk("chg_rd", rd, 32'h11);

      // Continuous tie: 4 back-to-back transactions
      g1_cycles = 0;
      m0_req = 1; m0_we = 0; m0_a = 0;
      m1_req = 1; m1_we = 0; m1_a = 2;
      for (int i = 0; i < 12; i++) begin
         step();
         if (m1_gnt) g1_cycles++;
      end
      clear_reqs();
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_m1_cycles", g1_cycles, 4);
`else
      chk("tie_m1_cycles", g1_cycles, 0);
`endif
      step();

      // Reset pulse during ACCESS of a write
      m0_req = 1; m0_we = 1; m0_a = 3; m0_wd = 32'hFFFF_FFFF;
      step();
      chk("rsta_swe_pre", s_we, 1);
      #1 rst = 1;
      #1;
      model_reset();
      chk("rsta_swe", s_we, 0);
      chk("rsta_gnt", m0_gnt, 0);
      chk("rsta_rd", rd, 0);
      chk("rsta_sa", s_a, 0);
      rst = 0;
      clear_reqs();
      step();
      chk("rsta_ack", m0_ack, 0);
      step();
      chk("rsta_mem", slv_mem[3], 0);

      // First tie after reset goes to m0 in both configurations
      m0_req = 1; m0_we = 0; m0_a = 3;
      m1_req = 1; m1_we = 0; m1_a = 3;
      step();
      chk("tie_first", m0_gnt, 1);
      clear_reqs();
      step();
      chk("tie_first_rd", rd, 0);
      step();

      // Randomized traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         rst    = ($urandom_range(0, 79) == 0);
         m0_req = ($urandom_range(0, 9) < 6);
         m1_req = ($urandom_range(0, 9) < 6);
         m0_we  = $urandom_range(0, 1);
         m1_we  = $urandom_range(0, 1);
         m0_a   = AW'($urandom_range(0, 3));
         m1_a   = AW'($urandom_range(0, 3));
         m0_wd  = $urandom;
         m1_wd  = $urandom;
         step();
      end
      rst = 0;
      clear_reqs();
      step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
